// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: instruction-store target of the fetch interface; returns the
// addressed word a fixed number of cycles after each accepted request, flagging bad fetches.
module inst_fetch_responder #(
   parameter int DEPTH_LOG2  = 6,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clka,
   input  logic                  rsta,
   input  logic                  ld_en,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [31:0]           ld_data,
   input  logic                  req_valid,
   input  logic [31:0]           req_addr,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [31:0]           resp_data,
   output logic                  resp_err,
   input  logic                  resp_ready,
   output logic [31:0]           fetch_count
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
   state_t state, next_state;
   logic [31:0] mem [2**DEPTH_LOG2];
   logic [31:0] addr, cap_addr;
   logic [3:0]  cnt;
   logic        accept, hs, enter_resp, cap_err;
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      accept     = 1'b0;
      hs         = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            accept    = req_valid;
            if (req_valid) next_state = (WAIT_STATES == 0) ? RESP : WAIT;
         end
         WAIT: if (cnt == 4'd0) next_state = RESP;
         RESP: begin
            hs = resp_valid && resp_ready;
            if (hs) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end
   // with no wait states the response is captured on the accept edge, straight from req_addr
   assign enter_resp = (next_state == RESP) && (state != RESP);
   assign cap_addr   = (state == IDLE) ? req_addr : addr;
   assign cap_err    = (cap_addr[1:0] != 2'b00) || ((cap_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
   always_ff @(posedge clka or posedge rsta)
      if (rsta) state <= IDLE;
      else state <= next_state;
   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         addr        <= 32'd0;
         cnt         <= 4'd0;
         resp_valid  <= 1'b0;
         resp_data   <= 32'd0;
         resp_err    <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         if (accept) begin
            addr <= req_addr;
            cnt  <= WS_INIT;
         end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
         if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_err   <= cap_err;
            resp_data  <= cap_err ? 32'd0 : mem[cap_addr[DEPTH_LOG2+1:2]];
         end else if (hs) begin
            resp_valid  <= 1'b0;
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end
   // store is deliberately unreset so a program survives rsta
   always_ff @(posedge clka)
      if (ld_en && !rsta) mem[ld_addr] <= ld_data;
endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb_inst_fetch_responder: directed and randomized fetches checked against a word-array
// model of the instruction store; a second instance covers the zero-wait-state case.
module tb_inst_fetch_responder;
   logic        clka = 1'b0, rsta = 1'b1, ld_en = 1'b0;
   logic [5:0]  ld_addr = 6'd0;
   logic [31:0] ld_data = 32'd0;
   logic        req_valid = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_data, fetch_count;
   logic        v0 = 1'b0, rr0 = 1'b0;
   logic [31:0] a0 = 32'd0;
   logic        rdy0, rv0, re0;
   logic [31:0] rd0, fc0;
   logic [31:0] mem [64];
   int          exp_cnt = 0, n_pass = 0, n_total = 0;

   inst_fetch_responder #(.DEPTH_LOG2(6), .WAIT_STATES(1)) dut (
      .clka(clka), .rsta(rsta), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .resp_ready(resp_ready), .fetch_count(fetch_count));

   inst_fetch_responder #(.DEPTH_LOG2(6), .WAIT_STATES(0)) dut0 (
      .clka(clka), .rsta(rsta), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .req_valid(v0), .req_addr(a0), .req_ready(rdy0),
      .resp_valid(rv0), .resp_data(rd0), .resp_err(re0),
      .resp_ready(rr0), .fetch_count(fc0));

   always #5 clka = ~clka;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clka);
      #1;
   endtask

   task automatic load(input int w, input logic [31:0] d);
      ld_en = 1'b1;
      ld_addr = 6'(w);
      ld_data = d;
      tick;
      ld_en = 1'b0;
      mem[w] = d;
   endtask

   function automatic logic is_err(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'h100);
   endfunction

   function automatic logic [31:0] exp_data(input logic [31:0] a);
      return is_err(a) ? 32'd0 : mem[a / 4];
   endfunction

   task automatic accept(input logic [31:0] a);
      int t = 0;
      req_valid = 1'b1;
      req_addr = a;
      while (!req_ready && t < 20) begin
         tick;
         t++;
      end
      chk("req_ready_before_accept", req_ready, 1);
      tick;
      req_valid = 1'b0;
      req_addr = $urandom;
      chk("req_ready_after_accept", req_ready, 0);
   endtask

   task automatic finish_resp(input logic [31:0] ed, input logic ee, input int bp, input int lat0);
      int lat = lat0;
      while (!resp_valid && lat < 20) begin
         tick;
         lat++;
      end
      chk("latency", lat, 2);
      chk("resp_data", resp_data, ed);
      chk("resp_err", resp_err, ee);
      chk("req_ready_in_resp", req_ready, 0);
      for (int i = 0; i < bp; i++) begin
         tick;
         chk("bp_valid", resp_valid, 1);
         chk("bp_data", resp_data, ed);
         chk("bp_ready", req_ready, 0);
         chk("bp_count", fetch_count, exp_cnt);
      end
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      exp_cnt++;
      chk("valid_after_hs", resp_valid, 0);
      chk("fetch_count", fetch_count, exp_cnt);
   endtask

   task automatic fetch(input logic [31:0] a, input int bp);
      logic [31:0] ed = exp_data(a);
      logic ee = is_err(a);
      accept(a);
      finish_resp(ed, ee, bp, 1);
   endtask

   initial begin
      logic [31:0] a;
      int sel;
      #3;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_fetch_count", fetch_count, 0);
      tick;
      rsta = 1'b0;
      for (int i = 0; i < 64; i++) load(i, $urandom);
      load(0, 32'h11111111);
      load(1, 32'h22222222);
      load(2, 32'h33333333);
      load(3, 32'h44444444);
      for (int i = 0; i < 4; i++) fetch(32'(i * 4), 0);
      chk("count_after_four", fetch_count, 4);
      // zero wait states: accept on even cycles, response on odd cycles
      rr0 = 1'b1;
      for (int c = 0; c < 8; c++) begin
         v0 = 1'b1;
         a0 = 32'((c / 2) * 4);
         chk("ws0_ready", rdy0, 32'(c % 2 == 0));
         chk("ws0_valid", rv0, 32'(c % 2 == 1));
         if (rv0) chk("ws0_data", rd0, mem[c / 2]);
         tick;
      end
      v0 = 1'b0;
      rr0 = 1'b0;
      chk("ws0_count", fc0, 4);
      fetch(32'h6, 0);
      fetch(32'h100, 0);
      fetch(32'h8, 5);
      accept(32'h4);
      rsta = 1'b1;
      #2;
      chk("midwait_rst_ready", req_ready, 1);
      chk("midwait_rst_valid", resp_valid, 0);
      chk("midwait_rst_count", fetch_count, 0);
      exp_cnt = 0;
      ld_en = 1'b1;
      ld_addr = 6'd1;
      ld_data = 32'h0BAD0BAD;
      tick;
      ld_en = 1'b0;
      rsta = 1'b0;
      tick;
      tick;
      chk("no_resp_after_rst", resp_valid, 0);
      fetch(32'h4, 0);
      accept(32'h4);
      ld_en = 1'b1;
      ld_addr = 6'd1;
      ld_data = 32'hDEADBEEF;
      tick;
      ld_en = 1'b0;
      chk("collision_old_word", resp_data, 32'h22222222);
      mem[1] = 32'hDEADBEEF;
      finish_resp(32'h22222222, 1'b0, 0, 2);
      fetch(32'h4, 0);
      for (int it = 0; it < 30; it++) begin
         repeat ($urandom_range(0, 2)) load($urandom_range(0, 63), $urandom);
         sel = $urandom_range(0, 7);
         a = (sel == 7) ? ($urandom | 32'h100) :
             (sel == 6) ? (32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3))) :
                          32'($urandom_range(0, 63)) * 4;
         fetch(a, $urandom_range(0, 3));
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
